// File: rtl/pipe_hold_ctrl_if.sv
// pipe_hold_ctrl_if: request inputs and hold/redirect outputs of the pipeline hold controller
interface pipe_hold_ctrl_if;
    logic        mem_wait_i;
    logic        div_busy_i;
    logic        jump_req_i;
    logic [63:0] jump_addr_i;
    logic        loaduse_req_i;
    logic [2:0]  hold_pc_o;
    logic [2:0]  hold_ifid_o;
    logic [2:0]  hold_idex_o;
    logic [2:0]  hold_exmem_o;
    logic [2:0]  hold_memwb_o;
    logic        redirect_o;
    logic [63:0] redirect_addr_o;
    logic [31:0] stall_cnt_o;
    logic        timeout_o;
    modport master (
        output mem_wait_i, div_busy_i, jump_req_i, jump_addr_i, loaduse_req_i,
        input  hold_pc_o, hold_ifid_o, hold_idex_o, hold_exmem_o, hold_memwb_o,
        input  redirect_o, redirect_addr_o, stall_cnt_o, timeout_o
    );
    modport slave (
        input  mem_wait_i, div_busy_i, jump_req_i, jump_addr_i, loaduse_req_i,
        output hold_pc_o, hold_ifid_o, hold_idex_o, hold_exmem_o, hold_memwb_o,
        output redirect_o, redirect_addr_o, stall_cnt_o, timeout_o
    );
endinterface

// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl: priority hold/flush/redirect controller for the 5-stage core.
// Define HOLD_CTRL_WATCHDOG_EN to build the hung-memory-access watchdog.
module pipe_hold_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input logic           clk,
    input logic           rst,
    pipe_hold_ctrl_if.slave bus
);
    localparam logic [2:0] PASS  = 3'b000;
    localparam logic [2:0] FLUSH = 3'b001;
    localparam logic [2:0] HOLD  = 3'b010;
    typedef enum logic [1:0] {RUN, MWAIT, DWAIT, REDIR} state_t;
    if (TIMEOUT <= 0 || TIMEOUT >= 2 ** CNT_W) begin : g_bad_param
        $error("TIMEOUT must fit in CNT_W bits");
    end
    state_t      state;
    state_t      next_state;
    logic [31:0] stall_cnt;
    logic [14:0] holds;
    logic        mw, dv, jp, lu_eff, redirect, timeout, drain;
    assign mw     = bus.mem_wait_i;
    assign dv     = bus.div_busy_i;
    assign jp     = bus.jump_req_i;
    // the cycle after a redirect ID holds a flushed bubble, so its load-use flag is stale
    assign lu_eff = bus.loaduse_req_i && state != REDIR;
    always_comb begin
        holds      = drain  ? {5{FLUSH}} :
                     mw     ? {HOLD, HOLD, HOLD, HOLD, FLUSH} :
                     dv     ? {HOLD, HOLD, HOLD, FLUSH, PASS} :
                     jp     ? {PASS, FLUSH, FLUSH, PASS, PASS} :
                     lu_eff ? {HOLD, HOLD, FLUSH, PASS, PASS} : '0;
        redirect   = jp && !mw && !dv;
        next_state = mw ? MWAIT : dv ? DWAIT : jp ? REDIR : RUN;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            stall_cnt <= '0;
        end else begin
            state <= next_state;
            if (holds[14:12] == HOLD) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`ifdef HOLD_CTRL_WATCHDOG_EN
    logic [CNT_W-1:0] wd_cnt;
    logic             timeout_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if (!mw) begin
            wd_cnt <= '0;
        end else if (state == MWAIT && wd_cnt != CNT_W'(TIMEOUT)) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
            if (wd_cnt == CNT_W'(TIMEOUT - 1)) timeout_q <= 1'b1;
        end
    end
    assign timeout = timeout_q;
    assign drain   = timeout_q && mw;
`else
    assign timeout = 1'b0;
    assign drain   = 1'b0;
`endif
    assign bus.hold_pc_o       = holds[14:12];
    assign bus.hold_ifid_o     = holds[11:9];
    assign bus.hold_idex_o     = holds[8:6];
    assign bus.hold_exmem_o    = holds[5:3];
    assign bus.hold_memwb_o    = holds[2:0];
    assign bus.redirect_o      = redirect;
    assign bus.redirect_addr_o = redirect ? bus.jump_addr_i : '0;
    assign bus.stall_cnt_o     = stall_cnt;
    assign bus.timeout_o       = timeout;
endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// tb_pipe_hold_ctrl: randomized scoreboard bench for pipe_hold_ctrl
module tb_pipe_hold_ctrl;
    localparam int TO = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    pipe_hold_ctrl_if bus();
    pipe_hold_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct packed {
        logic [14:0] holds;
        logic        redir;
        logic [63:0] addr;
        logic [31:0] stall;
        logic        tmo;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int failures = 0;
    logic        m_prev_redir, m_tmo;
    int          m_run;
    logic [31:0] m_stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_prev_redir = 0;
        m_tmo = 0;
        m_run = 0;
        m_stall = 0;
    endtask

    // one cycle of stimulus; expected response comes from the priority rules directly
    task automatic apply(input logic mw, input logic dv, input logic jp, input logic [63:0] a, input logic lu);
        exp_t e;
        @(posedge clk);
        #1;
        bus.mem_wait_i = mw;
        bus.div_busy_i = dv;
        bus.jump_req_i = jp;
        bus.jump_addr_i = a;
        bus.loaduse_req_i = lu;
        if (mw && m_tmo) e.holds = {5{3'b001}};
        else if (mw) e.holds = {3'b010, 3'b010, 3'b010, 3'b010, 3'b001};
        else if (dv) e.holds = {3'b010, 3'b010, 3'b010, 3'b001, 3'b000};
        else if (jp) e.holds = {3'b000, 3'b001, 3'b001, 3'b000, 3'b000};
        else if (lu && !m_prev_redir) e.holds = {3'b010, 3'b010, 3'b001, 3'b000, 3'b000};
        else e.holds = '0;
        e.redir = jp && !mw && !dv;
        e.addr = e.redir ? a : 64'd0;
        e.stall = m_stall;
        e.tmo = m_tmo;
        q.push_back(e);
        if (e.holds[14:12] == 3'b010) m_stall++;
        m_prev_redir = e.redir;
        m_run = mw ? m_run + 1 : 0;
`ifdef HOLD_CTRL_WATCHDOG_EN
        if (m_run == TO + 1) m_tmo = 1;
`endif
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && q.size() > 0) begin
                e = q.pop_front();
                check("holds", {bus.hold_pc_o, bus.hold_ifid_o, bus.hold_idex_o, bus.hold_exmem_o, bus.hold_memwb_o}, e.holds);
                check("redirect", bus.redirect_o, e.redir);
                check("redirect_addr", bus.redirect_addr_o, e.addr);
                check("stall_cnt", bus.stall_cnt_o, e.stall);
                check("timeout", bus.timeout_o, e.tmo);
            end
        end
    end

    initial begin
        logic mw;
        logic [63:0] a;
        bus.mem_wait_i = 0;
        bus.div_busy_i = 0;
        bus.jump_req_i = 0;
        bus.jump_addr_i = 0;
        bus.loaduse_req_i = 0;
        model_reset();
        #2;
        check("rst_holds", {bus.hold_pc_o, bus.hold_ifid_o, bus.hold_idex_o, bus.hold_exmem_o, bus.hold_memwb_o}, 0);
        check("rst_redirect", bus.redirect_o, 0);
        check("rst_stall", bus.stall_cnt_o, 0);
        check("rst_timeout", bus.timeout_o, 0);
        #10 rst = 1;
        repeat (10) apply(0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 0);
        apply(0, 0, 1, 64'h8000_0040, 0);
        apply(0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 0);
        a = 64'h0000_1234_5678_9ab0;
        repeat (3) apply(1, 1, 1, a, 0);
        repeat (2) apply(0, 1, 1, a, 0);
        apply(0, 0, 1, a, 0);
        apply(0, 0, 0, 0, 0);
        repeat (6) apply(1, 0, 0, 0, 0);
        repeat (3) apply(0, 0, 0, 0, 1);
        // asynchronous reset in the middle of a divide stall
        repeat (2) apply(0, 1, 0, 0, 0);
        @(negedge clk);
        #2 rst = 0;
        #1;
        check("arst_stall", bus.stall_cnt_o, 0);
        check("arst_timeout", bus.timeout_o, 0);
        check("arst_div_holds", {bus.hold_pc_o, bus.hold_ifid_o, bus.hold_idex_o, bus.hold_exmem_o, bus.hold_memwb_o},
              {3'b010, 3'b010, 3'b010, 3'b001, 3'b000});
        bus.div_busy_i = 0;
        bus.loaduse_req_i = 1;
        #0.5;
        check("arst_lu_holds", {bus.hold_pc_o, bus.hold_ifid_o, bus.hold_idex_o, bus.hold_exmem_o, bus.hold_memwb_o},
              {3'b010, 3'b010, 3'b001, 3'b000, 3'b000});
        bus.loaduse_req_i = 0;
        model_reset();
        #0.5 rst = 1;
        mw = 0;
        repeat (400) begin
            mw = mw ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 4) == 0);
            a = {$urandom, $urandom};
            apply(mw, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, a, $urandom_range(0, 1) == 1);
        end
        apply(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("queue_drained", 64'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
